// File: rtl/key_debounce_pkg.sv
// Shared types and key index constants for the push-button debounce front end.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_e;

    localparam int KEY_IDX_RESET   = 0;
    localparam int KEY_IDX_START   = 1;
    localparam int KEY_IDX_DISPLAY = 2;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, hold-time debounce FSM, press/release pulses.
// Auto-repeat while held is built only when KEY_REPEAT_EN is defined.
module key_debounce_ch
    import key_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Illegal configurations show up as this block in the elaborated hierarchy.
    if (DEBOUNCE_CYCLES < 2 || REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_illegal_params
    end

    logic             sync1_q, sync2_q;
    logic             pressed_s;
    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             repeat_fire;

    assign pressed_s = ~sync2_q;

    // State register; sync flops reset to the released level.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (reset) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= key_n;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pressed_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!pressed_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!pressed_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (pressed_s) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        level_d   = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
        press_d   = ((state_q == PRESS_WAIT) && (state_d == PRESSED)) || repeat_fire;
        release_d = (state_q == RELEASE_WAIT) && (state_d == IDLE);
    end

`ifdef KEY_REPEAT_EN
    localparam int               HOLD_W      = $clog2(REPEAT_DELAY + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [HOLD_W-1:0] hold_q, hold_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    // Held at zero outside PRESSED, so any entry (accept or bounce-back) restarts it.
    always_comb begin
        hold_d      = hold_q;
        repeat_fire = 1'b0;
        if (state_q != PRESSED) begin
            hold_d = '0;
        end else if (pressed_s) begin
            if (hold_q == HOLD_LAST) begin
                repeat_fire = 1'b1;
                hold_d      = HOLD_RELOAD;
            end else begin
                hold_d = hold_q + HOLD_W'(1);
            end
        end
    end
`else
    assign repeat_fire = 1'b0;
`endif

    assign key_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

endmodule

// File: rtl/key_debounce.sv
// Debounce front end for NUM_KEYS active-low push-buttons (one independent channel each).
// Define KEY_REPEAT_EN to add auto-repeat press pulses while a key is held.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int NUM_KEYS        = 3,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse
);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk           (clk),
            .reset         (reset),
            .key_n         (key_n[i]),
            .key_level     (key_level[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=6.
module tb_key_debounce;

    localparam int NK  = 3;
    localparam int DC  = 8;
    localparam int RD  = 20;
    localparam int RP  = 6;
    localparam int LAT = DC + 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [NK-1:0] key_n;
    logic [NK-1:0] key_level;
    logic [NK-1:0] press_pulse;
    logic [NK-1:0] release_pulse;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    key_debounce #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (DC),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .key_n         (key_n),
        .key_level     (key_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [NK-1:0] lvl,
                              input logic [NK-1:0] prs, input logic [NK-1:0] rel);
        check({tag, ".level"},   32'(key_level),     32'(lvl));
        check({tag, ".press"},   32'(press_pulse),   32'(prs));
        check({tag, ".release"}, 32'(release_pulse), 32'(rel));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 1000000");
        $fatal(1);
    end

    initial begin
        int pulses;
        int bad;
        logic [NK-1:0] exp_p;

        reset = 1'b1;
        key_n = '1;
        step(3);
        check_outs("reset", 3'b000, 3'b000, 3'b000);
        reset = 1'b0;
        step(2);
        check_outs("idle", 3'b000, 3'b000, 3'b000);

        // Clean press and release on key 1
        key_n[1] = 1'b0;
        step(LAT - 1);
        check_outs("press_early", 3'b000, 3'b000, 3'b000);
        step(1);
        check_outs("press_accept", 3'b010, 3'b010, 3'b000);
        step(1);
        check_outs("press_after", 3'b010, 3'b000, 3'b000);
        key_n[1] = 1'b1;
        step(LAT - 1);
        check_outs("rel_early", 3'b010, 3'b000, 3'b000);
        step(1);
        check_outs("rel_accept", 3'b000, 3'b000, 3'b010);
        step(1);
        check_outs("rel_after", 3'b000, 3'b000, 3'b000);

        // Bounce rejection on key 0: 5 low / 1 high x3, then held low
        pulses = 0;
        repeat (3) begin
            key_n[0] = 1'b0;
            repeat (5) begin
                step(1);
                pulses += int'(|press_pulse) + int'(|release_pulse) + int'(|key_level);
            end
            key_n[0] = 1'b1;
            step(1);
            pulses += int'(|press_pulse) + int'(|release_pulse) + int'(|key_level);
        end
        key_n[0] = 1'b0;
        repeat (LAT - 1) begin
            step(1);
            pulses += int'(|press_pulse) + int'(|release_pulse) + int'(|key_level);
        end
        check("bounce_quiet", 32'(pulses), 32'd0);
        step(1);
        check_outs("bounce_accept", 3'b001, 3'b001, 3'b000);

        // Release glitch on key 0: 3-cycle high while held
        step(2);
        key_n[0] = 1'b1;
        step(3);
        key_n[0] = 1'b0;
        bad = 0;
        repeat (10) begin
            step(1);
            bad += int'(release_pulse[0]) + int'(!key_level[0]);
        end
        check("glitch_no_release", 32'(bad), 32'd0);
        check("glitch_level", 32'(key_level), 32'(3'b001));
        key_n[0] = 1'b1;
        step(LAT - 1);
        check_outs("glitch_rel_early", 3'b001, 3'b000, 3'b000);
        step(1);
        check_outs("glitch_rel_accept", 3'b000, 3'b000, 3'b001);
        step(2);

        // All keys pressed together
        key_n = 3'b000;
        step(LAT - 1);
        check_outs("sim_early", 3'b000, 3'b000, 3'b000);
        step(1);
        check_outs("sim_accept", 3'b111, 3'b111, 3'b000);
        step(1);
        check_outs("sim_after", 3'b111, 3'b000, 3'b000);
        key_n = 3'b111;
        step(LAT);
        check_outs("sim_release", 3'b000, 3'b000, 3'b111);
        step(2);

        // Reset 4 cycles into PRESS_WAIT on key 2, key still held afterwards
        key_n[2] = 1'b0;
        step(7);
        reset = 1'b1;
        step(2);
        check_outs("rst_mid", 3'b000, 3'b000, 3'b000);
        reset = 1'b0;
        pulses = 0;
        repeat (LAT - 1) begin
            step(1);
            pulses += int'(|press_pulse) + int'(|key_level);
        end
        check("rst_quiet", 32'(pulses), 32'd0);
        step(1);
        check_outs("rst_accept", 3'b100, 3'b100, 3'b000);
        key_n[2] = 1'b1;
        step(LAT);
        check_outs("rst_release", 3'b000, 3'b000, 3'b100);
        step(2);

        // Long hold on key 1: auto-repeat only when built with KEY_REPEAT_EN
        key_n[1] = 1'b0;
        step(LAT);
        check_outs("hold_accept", 3'b010, 3'b010, 3'b000);
        for (int k = 1; k <= 60; k++) begin
            step(1);
`ifdef KEY_REPEAT_EN
            exp_p = (k >= RD && ((k - RD) % RP) == 0) ? 3'b010 : 3'b000;
`else
            exp_p = 3'b000;
`endif
            check($sformatf("hold_k%0d", k), 32'(press_pulse), 32'(exp_p));
        end
        key_n[1] = 1'b1;
        step(LAT);
        check_outs("hold_release", 3'b000, 3'b000, 3'b010);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
